// File: rtl/ntt_pkg.sv
// Shared constants, types and helpers for the 257-point circular-shift datapath.
package ntt_pkg;

  localparam int SIZE  = 257;
  localparam int WIDTH = 32;
  localparam int CNT_W = 9;

  localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } gather_state_t;

  // Any CNT_W-bit value is below 2*SIZE, so one conditional subtract is a full reduction.
  function automatic logic [CNT_W-1:0] mod_size(input logic [CNT_W-1:0] v);
    return (v >= SIZE_C) ? v - SIZE_C : v;
  endfunction

endpackage

// File: rtl/coeff_stream_gather.sv
// Serial-to-parallel gather: collects SIZE coefficients plus a reduced rotation
// amount and hands the vector to the circular_shift stage under valid/ready.
module coeff_stream_gather
  import ntt_pkg::*;
#(
  parameter int SIZE  = ntt_pkg::SIZE,
  parameter int WIDTH = ntt_pkg::WIDTH,
  parameter int CNT_W = ntt_pkg::CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [CNT_W-1:0]            in_shift,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SIZE-1:0][WIDTH-1:0]  out_list,
  output logic [CNT_W-1:0]            out_shift,
  output logic                        err_short,
  output logic                        err_long
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIZE - 1);

  gather_state_t              state_q;
  logic [CNT_W-1:0]           count_q;
  logic                       inReady_q;
  logic                       outValid_q;
  logic [SIZE-1:0][WIDTH-1:0] list_q;
  logic [CNT_W-1:0]           shift_q;
  logic                       errShort_q;
  logic                       errLong_q;

  logic                       xfer;
  logic                       atLast;
  logic [CNT_W-1:0]           shift_d;

  assign xfer    = in_valid && inReady_q;
  assign atLast  = (count_q == LAST_IDX);
  assign shift_d = mod_size(in_shift);

  // Handshake flags are registered alongside the state so neither output has a
  // combinational path from the stream inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      count_q    <= '0;
      inReady_q  <= 1'b0;
      outValid_q <= 1'b0;
      list_q     <= '0;
      shift_q    <= '0;
      errShort_q <= 1'b0;
      errLong_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          inReady_q <= 1'b1;
          if (xfer) begin
            list_q[count_q] <= in_data;
            if (count_q == '0) begin
              shift_q <= shift_d;
            end
            if (atLast) begin
              count_q    <= '0;
              state_q    <= FULL;
              inReady_q  <= 1'b0;
              outValid_q <= 1'b1;
              if (!in_last) begin
                errLong_q <= 1'b1;
              end
            end else if (in_last) begin
              // Short vector: drop it and let the next one overwrite the stale words.
              errShort_q <= 1'b1;
              count_q    <= '0;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state_q    <= LOAD;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= LOAD;
          count_q    <= '0;
          inReady_q  <= 1'b0;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign out_list  = list_q;
  assign out_shift = shift_q;
  assign err_short = errShort_q;
  assign err_long  = errLong_q;

endmodule

// File: tb/tb_coeff_stream_gather.sv
// Scoreboard bench for coeff_stream_gather: vectors are predicted as they are
// streamed in and compared when the block presents them.
module tb_coeff_stream_gather;

  localparam int SIZE  = 257;
  localparam int WIDTH = 32;
  localparam int CNT_W = 9;

  typedef logic [SIZE-1:0][WIDTH-1:0] vec_t;
  typedef struct packed {
    logic [CNT_W-1:0] shift;
    vec_t             list;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] in_shift;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  vec_t             out_list;
  logic [CNT_W-1:0] out_shift;
  logic             err_short;
  logic             err_long;

  exp_t sb[$];
  int   checkCount = 0;
  int   failCount  = 0;

  coeff_stream_gather #(
    .SIZE (SIZE),
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shift (in_shift),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_list (out_list),
    .out_shift(out_shift),
    .err_short(err_short),
    .err_long (err_long)
  );

  always #5 clk = ~clk;

  // Streams n words base+i; the rotation is driven only meaningfully on word 0,
  // later words carry random shift values that must be ignored.
  task automatic sendWords(input int n, input int base, input int shiftIn,
                           input bit lastOnFinal, input bit pushExp);
    exp_t e;
    e.list  = '0;
    e.shift = CNT_W'(shiftIn % SIZE);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      @(negedge clk);
      while (!in_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      checkCount++;
      if (in_ready !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL in_ready_during_load word %0d: got %b want 1", i, in_ready);
      end
      in_valid = 1'b1;
      in_data  = WIDTH'(base + i);
      in_shift = (i == 0) ? CNT_W'(shiftIn) : CNT_W'($urandom);
      in_last  = (i == n - 1) && lastOnFinal;
      e.list[i] = in_data;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (pushExp) sb.push_back(e);
  endtask

  task automatic checkDelivered(input string name);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkCount++;
    if (waited != 0 || out_valid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL %s_latency: out_valid after %0d extra cycles (=%b), want 0 extra", name, waited, out_valid);
    end
    checkCount++;
    if (sb.size() == 0) begin
      failCount++;
      $display("[TB] FAIL %s_scoreboard: got empty queue, want one expected vector", name);
      return;
    end
    e = sb.pop_front();
    if (out_shift !== e.shift) begin
      failCount++;
      $display("[TB] FAIL %s_shift: got %0d want %0d", name, out_shift, e.shift);
    end
    checkCount++;
    if (out_list !== e.list) begin
      int k = 0;
      while (k < SIZE - 1 && out_list[k] === e.list[k]) k++;
      failCount++;
      $display("[TB] FAIL %s_list: index %0d got %0d want %0d", name, k, out_list[k], e.list[k]);
    end
    if (out_ready) begin
      @(negedge clk);
      checkCount++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL %s_release: got valid=%b ready=%b want valid=0 ready=1", name, out_valid, in_ready);
      end
    end
  endtask

  task automatic checkResetValues(input string name);
    checkCount++;
    if (out_valid !== 1'b0 || out_list !== '0 || out_shift !== '0 ||
        err_short !== 1'b0 || err_long !== 1'b0 || in_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL %s_values: got valid=%b list_zero=%b shift=%0d es=%b el=%b ready=%b want 0/1/0/0/0/0",
               name, out_valid, (out_list == '0), out_shift, err_short, err_long, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checkCount++;
    if (in_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL %s_ready_after: got %b want 1", name, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
  endtask

  task automatic test_ramp();
    out_ready = 1'b1;
    sendWords(SIZE, 0, 5, 1'b1, 1'b1);
    checkDelivered("ramp");
    checkCount++;
    if (err_short !== 1'b0 || err_long !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL ramp_flags: got short=%b long=%b want 0 0", err_short, err_long);
    end
  endtask

  task automatic test_shift_reduction();
    int shifts[3] = '{300, 257, 511};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sendWords(SIZE, 500 * (k + 1), shifts[k], 1'b1, 1'b1);
      checkDelivered($sformatf("shift%0d", shifts[k]));
    end
  endtask

  task automatic test_back_pressure();
    exp_t e;
    out_ready = 1'b0;
    sendWords(SIZE, 2000, 17, 1'b1, 1'b1);
    e = sb[0];
    checkDelivered("bp");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkCount++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_list !== e.list || out_shift !== e.shift) begin
        failCount++;
        $display("[TB] FAIL bp_hold cycle %0d: got valid=%b ready=%b list_ok=%b shift=%0d want 1/0/1/%0d",
                 c, out_valid, in_ready, (out_list == e.list), out_shift, e.shift);
      end
      in_valid = 1'($urandom);
      in_data  = $urandom;
      in_last  = 1'($urandom);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkCount++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL bp_release: got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_short_vector();
    out_ready = 1'b1;
    sendWords(100, 7000, 3, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkCount++;
      if (out_valid !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL short_no_valid cycle %0d: got %b want 0", c, out_valid);
      end
    end
    checkCount++;
    if (err_short !== 1'b1 || err_long !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL short_flags: got short=%b long=%b want 1 0", err_short, err_long);
    end
    sendWords(SIZE, 1000, 9, 1'b1, 1'b1);
    checkDelivered("after_short");
  endtask

  task automatic test_long_vector();
    out_ready = 1'b1;
    sendWords(SIZE, 3000, 100, 1'b0, 1'b1);
    checkDelivered("long");
    checkCount++;
    if (err_long !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL long_flag: got %b want 1", err_long);
    end
    sendWords(SIZE, 4000, 1, 1'b1, 1'b1);
    checkDelivered("after_long");
    checkCount++;
    if (err_long !== 1'b1 || err_short !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL sticky_flags: got long=%b short=%b want 1 1", err_long, err_short);
    end
  endtask

  task automatic test_reset_mid_load();
    out_ready = 1'b1;
    sendWords(150, 5000, 7, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("mid_reset");
    sendWords(SIZE, 6000, 260, 1'b1, 1'b1);
    checkDelivered("after_reset");
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_ramp();
    test_shift_reduction();
    test_back_pressure();
    test_short_vector();
    test_long_vector();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
